// File: rtl/vga_frame_analyzer.sv
// Receive-side timing checker for the VGA generator: measures line/frame length,
// locks on the expected mode and reports background colour plus lit-pixel bounding box.
module vga_frame_analyzer #(
  parameter int H_TOTAL      = 800,
  parameter int V_TOTAL      = 449,
  parameter int H_SYNC_START = 16,
  parameter int V_SYNC_START = 12,
  parameter int H_VIS_START  = 160,
  parameter int V_VIS_START  = 49
) (
  input  logic       pulse25M,
  input  logic       reset,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic [2:0] red,
  input  logic [2:0] green,
  input  logic [2:0] blue,
  output logic       locked,
  output logic       frame_done,
  output logic       box_found,
  output logic [9:0] box_left,
  output logic [9:0] box_right,
  output logic [8:0] box_top,
  output logic [8:0] box_bottom,
  output logic [8:0] bg_color,
  output logic [1:0] lock_state
);

  typedef enum logic [1:0] {UNLOCKED = 2'd0, ACQ = 2'd1, LOCKED = 2'd2} lock_state_t;

  localparam logic [10:0] H_TOT = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT = 11'(V_TOTAL);
  localparam logic [10:0] H_OFF = 11'(H_SYNC_START);
  localparam logic [10:0] V_OFF = 11'(V_SYNC_START);
  localparam logic [10:0] H_VIS = 11'(H_VIS_START);
  localparam logic [10:0] V_VIS = 11'(V_VIS_START);

  lock_state_t state_q, state_d;
  logic       s_h_q, s_v_q, s_h_prev_q, s_v_prev_q;
  logic [8:0] s_rgb_q;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       line_err_q, line_err_d, first_h_q, first_h_d, first_v_q, first_v_d;
  logic [8:0] bg_run_q, bg_run_d;
  logic [9:0] min_x_q, min_x_d, max_x_q, max_x_d;
  logic [8:0] min_y_q, min_y_d, max_y_q, max_y_d;
  logic       found_run_q, found_run_d;
  logic       frame_done_q, frame_done_d, box_found_q, box_found_d;
  logic [9:0] box_left_q, box_left_d, box_right_q, box_right_d;
  logic [8:0] box_top_q, box_top_d, box_bottom_q, box_bottom_d;
  logic [8:0] bg_color_q, bg_color_d;

  logic        h_edge, v_edge, x_sat, line_bad, frame_chk, frame_good;
  logic        visible, bg_pix, lit;
  logic [10:0] px_sum, py_sum, px, py;

  // Edge detection works on the registered copies, so the counters and the
  // registered pixel both refer to the same pin edge.
  assign h_edge = s_h_prev_q & ~s_h_q;
  assign v_edge = ~s_v_prev_q & s_v_q;
  assign x_sat  = (x_q == 10'h3FF);

  always_comb begin
    px_sum     = {1'b0, x_q} + H_OFF;
    py_sum     = {1'b0, y_q} + V_OFF;
    px         = (px_sum >= H_TOT) ? px_sum - H_TOT : px_sum;
    py         = (py_sum >= V_TOT) ? py_sum - V_TOT : py_sum;
    line_bad   = h_edge && !first_h_q && (({1'b0, x_q} + 11'd1) != H_TOT);
    frame_chk  = v_edge && !first_v_q;
    frame_good = (({1'b0, y_q} + 11'd1) == V_TOT) && !line_err_q && !line_bad;
    visible    = (px >= H_VIS) && (py >= V_VIS);
    bg_pix     = (px == H_VIS) && (py == V_VIS);
    lit        = visible && !bg_pix && (s_rgb_q != bg_run_q);
  end

  always_comb begin
    state_d = state_q;
    if (x_sat || (line_bad && state_q != UNLOCKED)) begin
      state_d = UNLOCKED;
    end else if (frame_chk) begin
      if (!frame_good) begin
        state_d = UNLOCKED;
      end else begin
        case (state_q)
          UNLOCKED: state_d = ACQ;
          ACQ:      state_d = LOCKED;
          default:  state_d = LOCKED;
        endcase
      end
    end
  end

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    line_err_d   = line_err_q;
    first_h_d    = first_h_q;
    first_v_d    = first_v_q;
    bg_run_d     = bg_run_q;
    min_x_d      = min_x_q;
    max_x_d      = max_x_q;
    min_y_d      = min_y_q;
    max_y_d      = max_y_q;
    found_run_d  = found_run_q;
    frame_done_d = 1'b0;
    box_found_d  = box_found_q;
    box_left_d   = box_left_q;
    box_right_d  = box_right_q;
    box_top_d    = box_top_q;
    box_bottom_d = box_bottom_q;
    bg_color_d   = bg_color_q;

    if (h_edge)     x_d = 10'd0;
    else if (!x_sat) x_d = x_q + 10'd1;

    if (v_edge)                        y_d = 10'd0;
    else if (h_edge && y_q != 10'h3FF) y_d = y_q + 10'd1;

    if (h_edge) first_h_d = 1'b0;
    if (v_edge) first_v_d = 1'b0;

    if (v_edge)        line_err_d = 1'b0;
    else if (line_bad) line_err_d = 1'b1;

    if (bg_pix) bg_run_d = s_rgb_q;

    // Report the finished frame before the running box is re-armed.
    if (v_edge && state_q == LOCKED) begin
      frame_done_d = 1'b1;
      box_found_d  = found_run_q;
      bg_color_d   = bg_run_q;
      if (found_run_q) begin
        box_left_d   = min_x_q;
        box_right_d  = max_x_q;
        box_top_d    = min_y_q;
        box_bottom_d = max_y_q;
      end
    end

    if (v_edge) begin
      min_x_d     = 10'h3FF;
      max_x_d     = 10'h000;
      min_y_d     = 9'h1FF;
      max_y_d     = 9'h000;
      found_run_d = 1'b0;
    end else if (lit) begin
      found_run_d = 1'b1;
      if (px[9:0] < min_x_q) min_x_d = px[9:0];
      if (px[9:0] > max_x_q) max_x_d = px[9:0];
      if (py[8:0] < min_y_q) min_y_d = py[8:0];
      if (py[8:0] > max_y_q) max_y_d = py[8:0];
    end
  end

  always_ff @(posedge pulse25M or posedge reset) begin
    if (reset) begin
      state_q      <= UNLOCKED;
      s_h_q        <= 1'b0;
      s_v_q        <= 1'b0;
      s_h_prev_q   <= 1'b0;
      s_v_prev_q   <= 1'b0;
      s_rgb_q      <= 9'h000;
      x_q          <= 10'd0;
      y_q          <= 10'd0;
      line_err_q   <= 1'b0;
      first_h_q    <= 1'b1;
      first_v_q    <= 1'b1;
      bg_run_q     <= 9'h000;
      min_x_q      <= 10'h3FF;
      max_x_q      <= 10'h000;
      min_y_q      <= 9'h1FF;
      max_y_q      <= 9'h000;
      found_run_q  <= 1'b0;
      frame_done_q <= 1'b0;
      box_found_q  <= 1'b0;
      box_left_q   <= 10'd0;
      box_right_q  <= 10'd0;
      box_top_q    <= 9'd0;
      box_bottom_q <= 9'd0;
      bg_color_q   <= 9'h000;
    end else begin
      state_q      <= state_d;
      s_h_q        <= h_sync;
      s_v_q        <= v_sync;
      s_h_prev_q   <= s_h_q;
      s_v_prev_q   <= s_v_q;
      s_rgb_q      <= {red, green, blue};
      x_q          <= x_d;
      y_q          <= y_d;
      line_err_q   <= line_err_d;
      first_h_q    <= first_h_d;
      first_v_q    <= first_v_d;
      bg_run_q     <= bg_run_d;
      min_x_q      <= min_x_d;
      max_x_q      <= max_x_d;
      min_y_q      <= min_y_d;
      max_y_q      <= max_y_d;
      found_run_q  <= found_run_d;
      frame_done_q <= frame_done_d;
      box_found_q  <= box_found_d;
      box_left_q   <= box_left_d;
      box_right_q  <= box_right_d;
      box_top_q    <= box_top_d;
      box_bottom_q <= box_bottom_d;
      bg_color_q   <= bg_color_d;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign lock_state = state_q;
  assign frame_done = frame_done_q;
  assign box_found  = box_found_q;
  assign box_left   = box_left_q;
  assign box_right  = box_right_q;
  assign box_top    = box_top_q;
  assign box_bottom = box_bottom_q;
  assign bg_color   = bg_color_q;

endmodule
